// File: rtl/risc_alu_pkg.sv
// Shared definitions for the RISC ALU datapath blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_alu_pkg;

   // Default operand width for the serial add/subtract unit
   localparam int DEFAULT_WIDTH = 8;

   // Serial add/subtract control states; encoding 2'd3 is unused and recovers to idle
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : risc_alu_pkg

// File: rtl/full_adder_hh.sv
// Full adder composed of two half adders and an OR gate.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_hh (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha_ab (
      .a (a),
      .b (b),
      .s (s1),
      .c (c1)
   );

   half_adder u_ha_ci (
      .a (s1),
      .b (ci),
      .s (s),
      .c (c2)
   );

   // At most one of the two half-adder carries can be set, so OR merges them
   always_comb begin
      co = c1 | c2;
   end

endmodule : full_adder_hh

// File: rtl/half_adder.sv
// Single-bit half adder.
// Latency: purely combinational.
// Backpressure: none.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Sum and carry of two bits
   always_comb begin
      s = a ^ b;
      c = a & b;
   end

endmodule : half_adder

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, one bit per cycle through a single full adder.
// Latency: done pulses WIDTH cycles after the accepting edge; one op per WIDTH+1 cycles back-to-back.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is ignored, not queued.
module serial_addsub
   import risc_alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // Output holding registers: kept separate from the working shift/carry
   // registers so results stay stable while the next operation runs.
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic fa_s;
   logic fa_co;

   full_adder_hh u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state logic: accept, per-bit shift/add, and final result capture
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: invert b and seed the carry with 1
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            if (cnt_q == LAST_BIT) begin
               // MSB cycle: signed overflow is carry into MSB xor carry out of it
               state_d = ST_DONE;
               sum_d   = {fa_s, res_q[WIDTH-1:1]};
               cout_d  = fa_co;
               ovf_d   = carry_q ^ fa_co;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Status decoded only from registered state
   always_comb begin
      busy     = (state_q == ST_RUN);
      done     = (state_q == ST_DONE);
      sum      = sum_q;
      cout     = cout_q;
      overflow = ovf_q;
   end

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_serial_addsub;

   localparam int W = 8;
   localparam int MAX_WAIT = 20;

   logic         clk;
   logic         reset;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int n_checks;
   int n_fail;

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request at the next falling edge and wait for done.
   // lat counts falling edges after the request edge up to the one that sees done;
   // with acceptance on the following rising edge, done is expected at lat == W+1.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         output int busy_cnt, output int lat, output logic got_done);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; sub = isub;
      busy_cnt = 0; lat = 0; got_done = 1'b0;
      for (int i = 1; i <= MAX_WAIT && !got_done; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            got_done = 1'b1;
            lat = i;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      #1;
      n_checks++;
      if ({busy, done, sum, cout, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  busy, done, sum, cout, overflow);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_add();
      int bc, lat;
      logic got;
      // 0x5A + 0x3C = 0x96: no carry out, 90+60 overflows signed
      run_op(8'h5A, 8'h3C, 1'b0, bc, lat, got);
      n_checks++;
      if (!got || lat != W + 1 || bc != W) begin
         n_fail++;
         $display("FAIL add_timing: got_done=%b lat=%0d busy_cycles=%0d, required 1 %0d %0d",
                  got, lat, bc, W + 1, W);
      end
      n_checks++;
      if (sum !== 8'h96 || cout !== 1'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL add_5a_3c: sum=%h cout=%b ovf=%b, required 96 0 1", sum, cout, overflow);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
         n_fail++;
         $display("FAIL done_one_cycle: done=%b busy=%b sum=%h, required 0 0 96", done, busy, sum);
      end
      // 0xFF + 0x01 wraps to 0 with carry out, no signed overflow
      run_op(8'hFF, 8'h01, 1'b0, bc, lat, got);
      n_checks++;
      if (!got || sum !== 8'h00 || cout !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ff_01: done=%b sum=%h cout=%b ovf=%b, required 1 00 1 0",
                  got, sum, cout, overflow);
      end
   endtask

   task automatic test_sub();
      int bc, lat;
      logic got;
      // 0x10 - 0x20 = 0xF0 with borrow (cout=0), no signed overflow
      run_op(8'h10, 8'h20, 1'b1, bc, lat, got);
      n_checks++;
      if (!got || sum !== 8'hF0 || cout !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_10_20: done=%b sum=%h cout=%b ovf=%b, required 1 f0 0 0",
                  got, sum, cout, overflow);
      end
   endtask

   task automatic test_back_to_back();
      int bc, lat;
      logic got;
      logic got2;
      int lat2;
      // 0x80 - 0x01 = 0x7F: no borrow, -128-1 overflows signed
      run_op(8'h80, 8'h01, 1'b1, bc, lat, got);
      n_checks++;
      if (!got || sum !== 8'h7F || cout !== 1'b1 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_80_01: done=%b sum=%h cout=%b ovf=%b, required 1 7f 1 1",
                  got, sum, cout, overflow);
      end
      // Still in DONE: request 1+1, accepted on the next rising edge
      start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
      got2 = 1'b0; lat2 = 0;
      for (int i = 1; i <= MAX_WAIT && !got2; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 1) begin
            n_checks++;
            if (busy !== 1'b1 || sum !== 8'h7F || cout !== 1'b1 || overflow !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_hold_outputs: busy=%b sum=%h cout=%b ovf=%b, required 1 7f 1 1",
                        busy, sum, cout, overflow);
            end
         end
         if (done) begin
            got2 = 1'b1;
            lat2 = i;
         end
      end
      n_checks++;
      if (!got2 || lat2 != W + 1 || sum !== 8'h02 || cout !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_add_01_01: done=%b gap=%0d sum=%h cout=%b ovf=%b, required 1 %0d 02 0 0",
                  got2, lat2, sum, cout, overflow, W + 1);
      end
   endtask

   task automatic test_start_ignored();
      logic got;
      int lat;
      @(negedge clk);
      start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
      got = 1'b0; lat = 0;
      for (int i = 1; i <= MAX_WAIT && !got; i++) begin
         @(negedge clk);
         // Pulse start with other operands during RUN cycles 2 and 5
         if (i == 2 || i == 5) begin
            start = 1'b1; a = 8'hFF; b = 8'hEE; sub = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            got = 1'b1;
            lat = i;
         end
      end
      start = 1'b0;
      n_checks++;
      if (!got || lat != W + 1 || sum !== 8'h46 || cout !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL start_ignored: done=%b lat=%0d sum=%h cout=%b ovf=%b, required 1 %0d 46 0 0",
                  got, lat, sum, cout, overflow, W + 1);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL no_queued_op: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid_run();
      int bc, lat;
      logic got;
      logic saw_done;
      @(negedge clk);
      start = 1'b1; a = 8'h33; b = 8'h44; sub = 1'b0;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_before_reset: busy=%b, required 1", busy);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, sum, cout, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                  busy, done, sum, cout, overflow);
      end
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_fail++;
         $display("FAIL no_done_after_reset: activity=%b, required 0", saw_done);
      end
      // 0x7F + 0x01 = 0x80: no carry out, signed overflow
      run_op(8'h7F, 8'h01, 1'b0, bc, lat, got);
      n_checks++;
      if (!got || lat != W + 1 || bc != W || sum !== 8'h80 || cout !== 1'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_op: done=%b lat=%0d busy_cycles=%0d sum=%h cout=%b ovf=%b, required 1 %0d %0d 80 0 1",
                  got, lat, bc, sum, cout, overflow, W + 1, W);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_addsub

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial add/subtract unit for the RISC ALU datapath, directly downstream of `half_adder`. Each cycle it feeds one operand bit pair into a full adder built from two `half_adder` instances and registers the carry. A WIDTH-bit add or subtract finishes in WIDTH cycles under a start/busy/done handshake. It is the area-optimised alternative to the parallel adder for multi-cycle ALU operations.

## Interface
- `WIDTH`, default 8, is the operand and result width in bits. It must be at least 2.
- `clk` (in, 1): the single clock. All state changes on its rising edge.
- `reset` (in, 1): asynchronous, active-high reset.
- `start` (in, 1): requests an operation. It is sampled only when the unit can accept a request.
- `sub` (in, 1): selects the operation. 0 computes a+b; 1 computes a-b.
- `a` (in, WIDTH): first operand. Captured on the accepting edge.
- `b` (in, WIDTH): second operand. Captured on the accepting edge.
- `busy` (out, 1): high while the operation is in progress (state RUN).
- `done` (out, 1): one-cycle pulse that marks the result as valid.
- `sum` (out, WIDTH): the result. Held stable from `done` until the next accept.
- `cout` (out, 1): final carry out of the MSB. For subtraction, 1 means no borrow (a ≥ b unsigned).
- `overflow` (out, 1): two's-complement signed overflow flag.

## Operation
- States are IDLE, RUN and DONE.
- **Accept:** a request is accepted when `start`=1 and the state is IDLE or DONE.
- **On accept:**
  - Load the A shift register with `a`.
  - Load the B shift register with `b` if `sub`=0, or with `~b` if `sub`=1.
  - Set the carry register to `sub`.
  - Clear the bit counter to 0.
  - Go to RUN.
- **`start` in RUN:** ignored. No queuing, and the operand inputs are don't-care.
- **Each RUN cycle:**
  - The full adder takes A[0], B[0] and the carry.
  - Full-adder sum = s2 of (s1 = A[0]^B[0]) ^ carry; carry out = c1 | c2.
  - The sum bit shifts into the result register at the MSB, and the result register shifts right.
  - A and B shift right by one.
  - The carry register takes the new carry.
  - The counter increments.
- **Overflow tracking:** on the cycle where counter = WIDTH-1, latch carry-in XOR carry-out of that bit as `overflow`.
- **End of RUN:** when counter = WIDTH-1, the next edge goes to DONE. The result register then holds the full result, the carry register drives `cout`, and the overflow latch drives `overflow`.
- **DONE:** lasts exactly one cycle. It goes to RUN if `start`=1, otherwise to IDLE.
- **Arithmetic:** modulo 2^WIDTH. The counter is clog2(WIDTH) bits wide and never wraps within an operation.
- **Reset, asynchronous and valid at any time including mid-RUN:**
  - State goes to IDLE.
  - `busy`, `done`, `sum`, `cout` and `overflow` all go to 0, and the counter clears.
  - A partially computed result is discarded.

## Timing
- `busy` = (state==RUN) and `done` = (state==DONE). Both are decoded directly from registered state, with no combinational path from inputs.
- **Latency:** if `start` is accepted at edge k, then `busy` is high for cycles k+1 through k+WIDTH. `done` is high for exactly one cycle after edge k+WIDTH, and `sum`, `cout` and `overflow` are valid from that edge.
- **Back-to-back operation:** `start`=1 during DONE is accepted, so throughput is one operation every WIDTH+1 cycles.
- **Output stability:** `sum`, `cout` and `overflow` change only at the final RUN edge or on reset. They keep their last value through IDLE and during a new RUN.

## Structure
- **Shared package `risc_alu_pkg`:**
  - State encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - Default `WIDTH`=8.
  - Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- **Sub-module:** one sub-module, `full_adder_hh`, a combinational full adder built from two `half_adder` instances plus an OR gate. `serial_addsub` instantiates it once.
- **Top level** contains the FSM, the counter, the three shift registers, the carry register and the overflow latch.

## Test plan
- Add 8'h5A + 8'h3C with `sub`=0 → `done` pulses 8 cycles after accept with `sum`=8'h96, `cout`=0, `overflow`=1, and `busy` high for exactly 8 cycles.
- Add 8'hFF + 8'h01 → `sum`=8'h00, `cout`=1, `overflow`=0.
- Subtract 8'h10 − 8'h20 → `sum`=8'hF0, `cout`=0 (borrow), `overflow`=0.
- Subtract 8'h80 − 8'h01 → `sum`=8'h7F, `cout`=1, `overflow`=1. Then, with `start` held high in DONE, add 8'h01 + 8'h01 back-to-back → second `done` arrives 9 cycles after the first, with `sum`=8'h02.
- Pulse `start` (with different operands) on RUN cycles 2 and 5 → ignored, and the original result completes unchanged.
- Assert `reset` on RUN cycle 4 → all outputs go to 0 immediately, `done` never pulses, and the next `start` then runs to completion correctly.
